// File: rtl/bk_arith_pkg.sv
// Shared definitions for the Brent-Kung arithmetic blocks (adder and
// pipelined subtractor).
//   WIDTH_DEFAULT : default operand width
//   pg_t          : (generate, propagate) pair carried through the prefix tree
//   clog2_f       : ceil(log2(value)), usable in constant expressions
package bk_arith_pkg;

   localparam int WIDTH_DEFAULT = 32;

   typedef struct packed {
      logic g;
      logic p;
   } pg_t;

   function automatic int clog2_f(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res++;
         v = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/bk_prefix_cell.sv
// Brent-Kung (G,P) dot operator: o = hi o lo.
//   hi : group covering the more significant bits
//   lo : adjacent, less significant group
//   o  : merged group (G = Ghi | Phi&Glo, P = Phi&Plo)
module bk_prefix_cell
   import bk_arith_pkg::*;
(
   input  pg_t hi,
   input  pg_t lo,
   output pg_t o
);

   assign o.g = hi.g | (hi.p & lo.g);
   assign o.p = hi.p & lo.p;

endmodule

// File: rtl/bk_pipelined_subtractor.sv
// Three-stage pipelined Brent-Kung subtractor: diff = a - b - bin.
// Computed as a + ~b + ~bin through a Brent-Kung prefix tree:
//   S1 : p, g (carry-in folded into bit 0) and the first half of the up-sweep
//   S2 : remaining up-sweep levels; spine carries c[2^k] are complete here
//   S3 : down-sweep, diff / bout / ovf registered and driven straight out
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake
//   a, b, bin             : minuend, subtrahend, borrow-in
//   out_valid / out_ready : result handshake
//   diff, bout, ovf       : difference, borrow-out, signed overflow
module bk_pipelined_subtractor
   import bk_arith_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int LEVELS = clog2_f(WIDTH);
   localparam int UP_S1  = (LEVELS + 1) / 2;

   if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("bk_pipelined_subtractor: WIDTH must be a power of two in 8..64");
   end

   // ---------------- elastic control ----------------
   logic v1_q, v2_q, v3_q;
   logic v1_d, v2_d, v3_d;
   logic free1, free2, free3;
   logic load1, load2, load3;

   always_comb begin
      free3 = ~v3_q | out_ready;
      free2 = ~v2_q | free3;
      free1 = ~v1_q | free2;
      load3 = v2_q & free3;
      load2 = v1_q & free2;
      load1 = in_valid & free1;
      v3_d  = load3 | (v3_q & ~out_ready);
      v2_d  = load2 | (v2_q & ~free3);
      v1_d  = load1 | (v1_q & ~free2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         v3_q <= v3_d;
      end
   end

   assign in_ready  = free1;
   assign out_valid = v3_q;

   // ---------------- stage 1 ----------------
   logic [WIDTH-1:0] p0;
   logic [WIDTH-1:0] g0;
   logic             cin;
   pg_t  [WIDTH-1:0] lvl0;

   always_comb begin
      cin  = ~bin;
      p0   = a ^ ~b;
      g0   = a & ~b;
      lvl0 = '0;
      for (int i = 0; i < WIDTH; i++) begin
         lvl0[i].g = g0[i];
         lvl0[i].p = p0[i];
      end
      // Carry-in is absorbed into bit 0 so every prefix G[i:0] is c[i+1].
      lvl0[0].g = g0[0] | (p0[0] & cin);
      lvl0[0].p = p0[0] & cin;
   end

   pg_t  [WIDTH-1:0] s1_node_q, s1_node_d;
   logic [WIDTH-1:0] s1_p_q, s1_p_d;
   logic             s1_cin_q, s1_cin_d;
   logic             s1_a_msb_q, s1_a_msb_d;
   logic             s1_b_msb_q, s1_b_msb_d;

   // Up-sweep: level l merges node i with node i-2^(l-1) where i+1 is a
   // multiple of 2^l. Levels above UP_S1 start from the S1 register.
   for (genvar l = 1; l <= LEVELS; l++) begin : g_up
      pg_t [WIDTH-1:0] src;
      pg_t [WIDTH-1:0] n;
      if (l == 1) begin : g_src_in
         assign src = lvl0;
      end else if (l == UP_S1 + 1) begin : g_src_reg
         assign src = s1_node_q;
      end else begin : g_src_prev
         assign src = g_up[l-1].n;
      end
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (((i + 1) % (1 << l)) == 0) begin : g_cell
            bk_prefix_cell u_cell (
               .hi (src[i]),
               .lo (src[i - (1 << (l - 1))]),
               .o  (n[i])
            );
         end else begin : g_pass
            assign n[i] = src[i];
         end
      end
   end

   always_comb begin
      s1_node_d  = s1_node_q;
      s1_p_d     = s1_p_q;
      s1_cin_d   = s1_cin_q;
      s1_a_msb_d = s1_a_msb_q;
      s1_b_msb_d = s1_b_msb_q;
      if (load1) begin
         s1_node_d  = g_up[UP_S1].n;
         s1_p_d     = p0;
         s1_cin_d   = cin;
         s1_a_msb_d = a[WIDTH-1];
         s1_b_msb_d = b[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      s1_node_q  <= s1_node_d;
      s1_p_q     <= s1_p_d;
      s1_cin_q   <= s1_cin_d;
      s1_a_msb_q <= s1_a_msb_d;
      s1_b_msb_q <= s1_b_msb_d;
   end

   // ---------------- stage 2 ----------------
   pg_t  [WIDTH-1:0] s2_node_q, s2_node_d;
   logic [WIDTH-1:0] s2_p_q, s2_p_d;
   logic             s2_cin_q, s2_cin_d;
   logic             s2_a_msb_q, s2_a_msb_d;
   logic             s2_b_msb_q, s2_b_msb_d;

   always_comb begin
      s2_node_d  = s2_node_q;
      s2_p_d     = s2_p_q;
      s2_cin_d   = s2_cin_q;
      s2_a_msb_d = s2_a_msb_q;
      s2_b_msb_d = s2_b_msb_q;
      if (load2) begin
         s2_node_d  = g_up[LEVELS].n;
         s2_p_d     = s1_p_q;
         s2_cin_d   = s1_cin_q;
         s2_a_msb_d = s1_a_msb_q;
         s2_b_msb_d = s1_b_msb_q;
      end
   end

   always_ff @(posedge clk) begin
      s2_node_q  <= s2_node_d;
      s2_p_q     <= s2_p_d;
      s2_cin_q   <= s2_cin_d;
      s2_a_msb_q <= s2_a_msb_d;
      s2_b_msb_q <= s2_b_msb_d;
   end

   // ---------------- stage 3 ----------------
   // Down-sweep: level d fills node i (i >= 2^d, i+1 = 2^(d-1) mod 2^d)
   // from the completed prefix 2^(d-1) positions below it.
   for (genvar d = LEVELS - 1; d >= 1; d--) begin : g_dn
      pg_t [WIDTH-1:0] src;
      pg_t [WIDTH-1:0] n;
      if (d == LEVELS - 1) begin : g_src_reg
         assign src = s2_node_q;
      end else begin : g_src_prev
         assign src = g_dn[d+1].n;
      end
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i >= (1 << d) && ((i + 1) % (1 << d)) == (1 << (d - 1))) begin : g_cell
            bk_prefix_cell u_cell (
               .hi (src[i]),
               .lo (src[i - (1 << (d - 1))]),
               .o  (n[i])
            );
         end else begin : g_pass
            assign n[i] = src[i];
         end
      end
   end

   pg_t  [WIDTH-1:0] fin;
   logic [WIDTH-1:0] carry_vec;
   logic [WIDTH-1:0] unused_fin_p;
   logic [WIDTH-1:0] diff_q, diff_d, diff_calc;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;

   assign fin = g_dn[1].n;

   always_comb begin
      carry_vec[0] = s2_cin_q;
      for (int i = 1; i < WIDTH; i++) begin
         carry_vec[i] = fin[i-1].g;
      end
      for (int i = 0; i < WIDTH; i++) begin
         unused_fin_p[i] = fin[i].p;
      end
      diff_calc = s2_p_q ^ carry_vec;
      diff_d    = diff_q;
      bout_d    = bout_q;
      ovf_d     = ovf_q;
      if (load3) begin
         diff_d = diff_calc;
         bout_d = ~fin[WIDTH-1].g;
         ovf_d  = (s2_a_msb_q ^ s2_b_msb_q) & (s2_a_msb_q ^ diff_calc[WIDTH-1]);
      end
   end

   // Result flops are cleared by reset so the outputs read zero while reset
   // is held and no stale value survives an abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         diff_q <= '0;
         bout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         diff_q <= diff_d;
         bout_q <= bout_d;
         ovf_q  <= ovf_d;
      end
   end

   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_bk_pipelined_subtractor.sv
module tb_bk_pipelined_subtractor;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] diff;
   logic        bout;
   logic        ovf;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [31:0] d;
      logic        bo;
      logic        ov;
   } res_t;

   res_t sb[$];

   bk_pipelined_subtractor #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin);
      logic [32:0] t;
      res_t r;
      t    = {1'b0, ma} - {1'b0, mb} - {32'd0, mbin};
      r.d  = t[31:0];
      r.bo = t[32];
      r.ov = (ma[31] ^ mb[31]) & (ma[31] ^ t[31]);
      return r;
   endfunction

   // Directed single transfer with out_ready high; checks 3-cycle latency.
   task automatic send_one(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                           input logic tbin, input logic [31:0] e_diff, input logic e_bout,
                           input logic e_ovf);
      int cyc;
      a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
      #1;
      chk({tag, "_in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_latency"}, cyc, 3);
      chk({tag, "_diff"}, diff, e_diff);
      chk({tag, "_bout"}, bout, e_bout);
      chk({tag, "_ovf"}, ovf, e_ovf);
      @(posedge clk); #1;
      chk({tag, "_consumed"}, out_valid, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   acc;
      bit   hold_pend;
      logic [33:0] held;
      int   acc_cnt;
      int   idx;
      int   sent;
      int   cyc;
      res_t e;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_diff", diff, 0);
      chk("rst_bout", bout, 0);
      chk("rst_ovf", ovf, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);

      out_ready = 1'b1;
      send_one("t1", 32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
      send_one("t2", 32'd3, 32'd5, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
      send_one("t3", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
      send_one("t4a", 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
      send_one("t4b", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1);

      // Backpressure: five operands k, k-1 for k = 10..14 with out_ready low.
      out_ready = 1'b0;
      acc_cnt = 0; idx = 0;
      a = 32'd10; b = 32'd9; bin = 1'b0; in_valid = 1'b1;
      #1;
      for (int c = 0; c < 8; c++) begin
         acc = in_valid & in_ready;
         @(posedge clk); #1;
         if (acc) begin
            acc_cnt++; idx++;
            if (idx < 5) begin a = 32'd10 + idx; b = 32'd9 + idx; end
            else in_valid = 1'b0;
         end
      end
      chk("bp_accepted", acc_cnt, 3);
      chk("bp_in_ready", in_ready, 0);
      for (int c = 0; c < 4; c++) begin
         chk("bp_out_valid", out_valid, 1);
         chk("bp_hold_diff", diff, 1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      for (int c = 0; c < 5; c++) begin
         chk("drain_valid", out_valid, 1);
         chk("drain_diff", diff, 1);
         chk("drain_bout", bout, 0);
         acc = in_valid & in_ready;
         @(posedge clk); #1;
         if (acc) begin
            acc_cnt++; idx++;
            if (idx < 5) begin a = 32'd10 + idx; b = 32'd9 + idx; end
            else in_valid = 1'b0;
         end
      end
      chk("drain_empty", out_valid, 0);
      chk("drain_all_accepted", acc_cnt, 5);
      in_valid = 1'b0;

      // Reset with two results in flight, one of them already presented.
      a = 32'd100; b = 32'd1; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 32'd200; b = 32'd2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_pre_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_async_valid", out_valid, 0);
      chk("rst_mid_diff", diff, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rst_mid_in_ready", in_ready, 1);
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         chk("rst_mid_no_stale", out_valid, 0);
      end

      // Random traffic against the reference model.
      sent = 0; cyc = 0; hold_pend = 1'b0; held = '0;
      in_valid = 1'b0;
      while ((sent < 10000 || sb.size() != 0) && cyc < 60000) begin
         if (!in_valid && sent < 10000 && $urandom_range(0, 4) != 0) begin
            a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
         end
         out_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         if (hold_pend) chk("rnd_hold", {diff, bout, ovf}, held);
         hold_pend = out_valid & ~out_ready;
         held      = {diff, bout, ovf};
         acc = in_valid & in_ready;
         if (acc) begin
            sb.push_back(model(a, b, bin));
            sent++;
         end
         if (out_valid && out_ready) begin
            chk("rnd_sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("rnd_diff", diff, e.d);
               chk("rnd_bout", bout, e.bo);
               chk("rnd_ovf", ovf, e.ov);
            end
         end
         @(posedge clk); #1;
         cyc++;
         if (acc) in_valid = 1'b0;
      end
      chk("rnd_in_time", cyc < 60000, 1);
      chk("rnd_sent", sent, 10000);
      chk("rnd_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
